// File: rtl/streamx_feeder.sv
// Primes a host-fed FIFO, then pops one word into write_data every 2^PERIOD_LOG2 cycles; optional underrun counter under STREAMX_FEEDER_UNDERRUN_CNT_EN.
// Latency: a pushed word is poppable the cycle after its push; write_data updates at the strobe edge.
// Backpressure: host_ready drops when the FIFO is full or flush is high; pop cadence is never stalled.
module streamx_feeder #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 8,
    parameter int PERIOD_LOG2 = 2,
    parameter int PRIME_LVL   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_l,
    input  logic                       i_host_valid,
    input  logic [DATA_W-1:0]          i_host_data,
    output logic                       o_host_ready,
    input  logic                       i_flush,
    output logic [DATA_W-1:0]          o_write_data,
    output logic                       o_write_strobe,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_running,
    output logic [15:0]                o_underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]             r_state;
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;
    logic [PERIOD_LOG2-1:0] r_cad;
    logic [DATA_W-1:0]      r_write_data;
    logic [DATA_W-1:0]      r_mem [DEPTH];

    logic [LW-1:0] w_level;
    logic          w_empty;
    logic          w_full;
    logic          w_strobe;
    logic          w_push;
    logic          w_pop;
    logic          w_prime_done;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign w_level      = LW'(r_wr_ptr - r_rd_ptr);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_prime_done = (w_level >= LW'(PRIME_LVL));
    assign w_strobe     = (r_state == ST_RUN) && (&r_cad);
    assign w_push       = i_host_valid && o_host_ready;
    assign w_pop        = w_strobe && !w_empty && !i_flush;

    assign o_host_ready   = i_rst_l && !w_full && !i_flush;
    assign o_write_data   = r_write_data;
    assign o_write_strobe = w_strobe;
    assign o_level        = w_level;
    assign o_running      = (r_state == ST_RUN);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_host_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_state      <= ST_PRIME;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cad        <= '0;
            r_write_data <= '0;
        end else if (i_flush) begin
            r_state  <= ST_PRIME;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cad    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_write_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
            if (r_state == ST_PRIME) begin
                r_cad <= '0;
                if (w_prime_done) begin
                    r_state <= ST_RUN;
                end
            end else begin
                r_cad <= r_cad + PERIOD_LOG2'(1);
            end
        end
    end

`ifdef STREAMX_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;
    logic        w_underrun;

    assign w_underrun     = w_strobe && w_empty && !i_flush;
    assign o_underrun_cnt = r_underrun_cnt;

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_underrun_cnt <= 16'h0;
        end else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'h1;
        end
    end
`else
    assign o_underrun_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_streamx_feeder.sv
// Directed bench for streamx_feeder: instance a primes at 2 words, instance b at 8 words (full scenario).
`ifndef DUT_WRITE_SIZE
`define DUT_WRITE_SIZE 64
`endif

module tb_streamx_feeder;

    localparam int DW = `DUT_WRITE_SIZE;
    localparam int LW = 4;

`ifdef STREAMX_FEEDER_UNDERRUN_CNT_EN
    localparam logic [15:0] EXP_UR1 = 16'd1;
`else
    localparam logic [15:0] EXP_UR1 = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_l;
    logic          host_valid;
    logic          flush;
    logic [DW-1:0] host_data;

    logic          ready_a, strobe_a, running_a;
    logic [DW-1:0] wd_a;
    logic [LW-1:0] lvl_a;
    logic [15:0]   ur_a;

    logic          ready_b, strobe_b, running_b;
    logic [DW-1:0] wd_b;
    logic [LW-1:0] lvl_b;
    logic [15:0]   ur_b;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    streamx_feeder #(.DATA_W(`DUT_WRITE_SIZE), .DEPTH(8), .PERIOD_LOG2(2), .PRIME_LVL(2)) u_dut_a (
        .i_clk(clk), .i_rst_l(rst_l), .i_host_valid(host_valid), .i_host_data(host_data),
        .o_host_ready(ready_a), .i_flush(flush), .o_write_data(wd_a), .o_write_strobe(strobe_a),
        .o_level(lvl_a), .o_running(running_a), .o_underrun_cnt(ur_a)
    );

    streamx_feeder #(.DATA_W(`DUT_WRITE_SIZE), .DEPTH(8), .PERIOD_LOG2(2), .PRIME_LVL(8)) u_dut_b (
        .i_clk(clk), .i_rst_l(rst_l), .i_host_valid(host_valid), .i_host_data(host_data),
        .o_host_ready(ready_b), .i_flush(flush), .o_write_data(wd_b), .o_write_strobe(strobe_b),
        .o_level(lvl_b), .o_running(running_b), .o_underrun_cnt(ur_b)
    );

    // All sampling and driving happens 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_l      = 1'b0;
        host_valid = 1'b0;
        flush      = 1'b0;
        host_data  = '0;
        tick(2);
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        rst_l      = 1'b0;
        host_valid = 1'b0;
        flush      = 1'b0;
        host_data  = '0;
        tick(2);
        chk_cnt++; if (ready_a !== 1'b0) $display("FAIL reset_ready: got %0b want 0", ready_a); else pass_cnt++;
        chk_cnt++; if (lvl_a !== 4'd0) $display("FAIL reset_level: got %0d want 0", lvl_a); else pass_cnt++;
        chk_cnt++; if (running_a !== 1'b0) $display("FAIL reset_running: got %0b want 0", running_a); else pass_cnt++;
        chk_cnt++; if (strobe_a !== 1'b0) $display("FAIL reset_strobe: got %0b want 0", strobe_a); else pass_cnt++;
        chk_cnt++; if (wd_a !== DW'(0)) $display("FAIL reset_write_data: got %0h want 0", wd_a); else pass_cnt++;
        chk_cnt++; if (ur_a !== 16'd0) $display("FAIL reset_underrun: got %0d want 0", ur_a); else pass_cnt++;
        rst_l = 1'b1;
        #1;
        chk_cnt++; if (ready_a !== 1'b1) $display("FAIL release_ready: got %0b want 1", ready_a); else pass_cnt++;
    endtask

    task automatic test_prime(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        host_valid = 1'b1;
        host_data  = d0;
        tick(1);
        host_data  = d1;
        tick(1);
        host_valid = 1'b0;
        chk_cnt++; if (lvl_a !== 4'd2) $display("FAIL prime_level: got %0d want 2", lvl_a); else pass_cnt++;
        chk_cnt++; if (running_a !== 1'b0) $display("FAIL prime_still_prime: got %0b want 0", running_a); else pass_cnt++;
        tick(1);
        chk_cnt++; if (running_a !== 1'b1) $display("FAIL prime_enter_run: got %0b want 1", running_a); else pass_cnt++;
        chk_cnt++; if (strobe_a !== 1'b0) $display("FAIL prime_no_early_strobe0: got %0b want 0", strobe_a); else pass_cnt++;
        tick(2);
        chk_cnt++; if (strobe_a !== 1'b0) $display("FAIL prime_no_early_strobe2: got %0b want 0", strobe_a); else pass_cnt++;
        tick(1);
        chk_cnt++; if (strobe_a !== 1'b1) $display("FAIL prime_first_strobe: got %0b want 1", strobe_a); else pass_cnt++;
        chk_cnt++; if (wd_a !== DW'(0)) $display("FAIL prime_wd_before_pop: got %0h want 0", wd_a); else pass_cnt++;
        tick(1);
        chk_cnt++; if (wd_a !== d0) $display("FAIL prime_wd_first: got %0h want %0h", wd_a, d0); else pass_cnt++;
        chk_cnt++; if (lvl_a !== 4'd1) $display("FAIL prime_level_after_pop: got %0d want 1", lvl_a); else pass_cnt++;
        chk_cnt++; if (strobe_a !== 1'b0) $display("FAIL prime_strobe_after_pop: got %0b want 0", strobe_a); else pass_cnt++;
    endtask

    task automatic test_full();
        do_reset();
        host_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_data = DW'(32'h10 + i);
            #1;
            chk_cnt++; if (ready_b !== 1'b1) $display("FAIL full_ready_word%0d: got %0b want 1", i, ready_b); else pass_cnt++;
            tick(1);
        end
        host_data = DW'(32'h18);
        #1;
        chk_cnt++; if (ready_b !== 1'b0) $display("FAIL full_ready_low: got %0b want 0", ready_b); else pass_cnt++;
        chk_cnt++; if (lvl_b !== 4'd8) $display("FAIL full_level: got %0d want 8", lvl_b); else pass_cnt++;
        chk_cnt++; if (running_b !== 1'b0) $display("FAIL full_prime: got %0b want 0", running_b); else pass_cnt++;
        tick(1);
        chk_cnt++; if (running_b !== 1'b1) $display("FAIL full_enter_run: got %0b want 1", running_b); else pass_cnt++;
        tick(3);
        chk_cnt++; if (strobe_b !== 1'b1) $display("FAIL full_strobe: got %0b want 1", strobe_b); else pass_cnt++;
        chk_cnt++; if (ready_b !== 1'b0) $display("FAIL full_ready_at_strobe: got %0b want 0", ready_b); else pass_cnt++;
        tick(1);
        chk_cnt++; if (ready_b !== 1'b1) $display("FAIL full_ready_after_pop: got %0b want 1", ready_b); else pass_cnt++;
        chk_cnt++; if (lvl_b !== 4'd7) $display("FAIL full_level_after_pop: got %0d want 7", lvl_b); else pass_cnt++;
        chk_cnt++; if (wd_b !== DW'(32'h10)) $display("FAIL full_wd: got %0h want 10", wd_b); else pass_cnt++;
        tick(1);
        host_valid = 1'b0;
        chk_cnt++; if (lvl_b !== 4'd8) $display("FAIL full_ninth_accepted: got %0d want 8", lvl_b); else pass_cnt++;
    endtask

    task automatic test_underrun();
        do_reset();
        host_valid = 1'b1;
        host_data  = DW'(32'h31);
        tick(1);
        host_data  = DW'(32'h32);
        tick(1);
        host_valid = 1'b0;
        tick(5);
        chk_cnt++; if (wd_a !== DW'(32'h31)) $display("FAIL ur_pop1: got %0h want 31", wd_a); else pass_cnt++;
        tick(4);
        chk_cnt++; if (wd_a !== DW'(32'h32)) $display("FAIL ur_pop2: got %0h want 32", wd_a); else pass_cnt++;
        chk_cnt++; if (lvl_a !== 4'd0) $display("FAIL ur_drained: got %0d want 0", lvl_a); else pass_cnt++;
        chk_cnt++; if (ur_a !== 16'd0) $display("FAIL ur_cnt_before: got %0d want 0", ur_a); else pass_cnt++;
        tick(3);
        chk_cnt++; if (strobe_a !== 1'b1) $display("FAIL ur_strobe: got %0b want 1", strobe_a); else pass_cnt++;
        tick(1);
        chk_cnt++; if (wd_a !== DW'(32'h32)) $display("FAIL ur_wd_hold: got %0h want 32", wd_a); else pass_cnt++;
        chk_cnt++; if (ur_a !== EXP_UR1) $display("FAIL ur_cnt_after: got %0d want %0d", ur_a, EXP_UR1); else pass_cnt++;
        chk_cnt++; if (running_a !== 1'b1) $display("FAIL ur_stays_run: got %0b want 1", running_a); else pass_cnt++;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk_cnt++; if (running_a !== 1'b0) $display("FAIL ur_flush_prime: got %0b want 0", running_a); else pass_cnt++;
        chk_cnt++; if (ur_a !== EXP_UR1) $display("FAIL ur_flush_keep_cnt: got %0d want %0d", ur_a, EXP_UR1); else pass_cnt++;
        chk_cnt++; if (wd_a !== DW'(32'h32)) $display("FAIL ur_flush_keep_wd: got %0h want 32", wd_a); else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        host_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            host_data = DW'(32'h51 + i);
            tick(1);
        end
        host_valid = 1'b0;
        tick(1);
        chk_cnt++; if (lvl_a !== 4'd5) $display("FAIL flush_pre_level: got %0d want 5", lvl_a); else pass_cnt++;
        chk_cnt++; if (running_a !== 1'b1) $display("FAIL flush_pre_run: got %0b want 1", running_a); else pass_cnt++;
        chk_cnt++; if (wd_a !== DW'(32'h51)) $display("FAIL flush_pre_wd: got %0h want 51", wd_a); else pass_cnt++;
        flush      = 1'b1;
        host_valid = 1'b1;
        host_data  = DW'(32'hEE);
        #1;
        chk_cnt++; if (ready_a !== 1'b0) $display("FAIL flush_ready: got %0b want 0", ready_a); else pass_cnt++;
        tick(1);
        flush      = 1'b0;
        host_valid = 1'b0;
        chk_cnt++; if (lvl_a !== 4'd0) $display("FAIL flush_level: got %0d want 0", lvl_a); else pass_cnt++;
        chk_cnt++; if (running_a !== 1'b0) $display("FAIL flush_prime: got %0b want 0", running_a); else pass_cnt++;
        chk_cnt++; if (wd_a !== DW'(32'h51)) $display("FAIL flush_wd_kept: got %0h want 51", wd_a); else pass_cnt++;
        tick(6);
        chk_cnt++; if (lvl_a !== 4'd0) $display("FAIL flush_nothing_accepted: got %0d want 0", lvl_a); else pass_cnt++;
        chk_cnt++; if (running_a !== 1'b0) $display("FAIL flush_empty_prime: got %0b want 0", running_a); else pass_cnt++;
        chk_cnt++; if (strobe_a !== 1'b0) $display("FAIL flush_no_strobe: got %0b want 0", strobe_a); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        host_valid = 1'b1;
        host_data  = DW'(32'h41);
        tick(1);
        host_data  = DW'(32'h42);
        tick(1);
        host_data  = DW'(32'h43);
        tick(1);
        host_valid = 1'b0;
        tick(4);
        chk_cnt++; if (wd_a !== DW'(32'h41)) $display("FAIL rmid_pop1: got %0h want 41", wd_a); else pass_cnt++;
        tick(3);
        chk_cnt++; if (strobe_a !== 1'b1) $display("FAIL rmid_strobe: got %0b want 1", strobe_a); else pass_cnt++;
        rst_l = 1'b0;
        #1;
        chk_cnt++; if (wd_a !== DW'(0)) $display("FAIL rmid_wd: got %0h want 0", wd_a); else pass_cnt++;
        chk_cnt++; if (strobe_a !== 1'b0) $display("FAIL rmid_strobe_low: got %0b want 0", strobe_a); else pass_cnt++;
        chk_cnt++; if (running_a !== 1'b0) $display("FAIL rmid_running: got %0b want 0", running_a); else pass_cnt++;
        chk_cnt++; if (lvl_a !== 4'd0) $display("FAIL rmid_level: got %0d want 0", lvl_a); else pass_cnt++;
        chk_cnt++; if (ready_a !== 1'b0) $display("FAIL rmid_ready: got %0b want 0", ready_a); else pass_cnt++;
        tick(1);
        rst_l = 1'b1;
    endtask

    task automatic test_wrap();
        int push_idx = 0;
        int exp_idx  = 0;
        int cyc      = 0;
        logic do_push;
        logic saw_strobe;
        do_reset();
        while (exp_idx < 40 && cyc < 400) begin
            host_valid = (push_idx < 40);
            host_data  = DW'(push_idx);
            #1;
            do_push    = host_valid && ready_a;
            saw_strobe = strobe_a;
            tick(1);
            if (do_push) push_idx++;
            if (saw_strobe) begin
                chk_cnt++; if (wd_a !== DW'(exp_idx)) $display("FAIL wrap_word%0d: got %0h want %0h", exp_idx, wd_a, exp_idx); else pass_cnt++;
                exp_idx++;
            end
            cyc++;
        end
        host_valid = 1'b0;
        chk_cnt++; if (exp_idx != 40) $display("FAIL wrap_timeout: got %0d words want 40", exp_idx); else pass_cnt++;
        chk_cnt++; if (ur_a !== 16'd0) $display("FAIL wrap_underrun: got %0d want 0", ur_a); else pass_cnt++;
    endtask

    initial begin
        rst_l      = 1'b0;
        host_valid = 1'b0;
        flush      = 1'b0;
        host_data  = '0;
        test_reset();
        test_prime(DW'(32'hA1), DW'(32'hA2));
        test_full();
        test_underrun();
        test_flush();
        test_reset_mid();
        test_prime(DW'(32'hB1), DW'(32'hB2));
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/streamx_feeder.md
STREAMX_FEEDER -- requirements
Module: streamx_feeder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the word width; instantiations set it to `DUT_WRITE_SIZE.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the FIFO entries; it is a power of two, at least 2.
REQ-003 The block SHALL have parameter PERIOD_LOG2, default 2, so that write_strobe fires once every 2^PERIOD_LOG2 cycles in RUN.
REQ-004 The block SHALL have parameter PRIME_LVL, default 2, giving the FIFO level required to leave PRIME; range 1..DEPTH.
REQ-005 clk  in  1  single clock; every register is on posedge clk.
REQ-006 rst_l  in  1  asynchronous, active-low reset.
REQ-007 host_valid  in  1  host word offered.
REQ-008 host_data  in  DATA_W  host word.
REQ-009 host_ready  out  1  the FIFO accepts a word this cycle.
REQ-010 flush  in  1  synchronous flush, one-cycle pulse or level.
REQ-011 write_data  out  DATA_W  word presented to the streamx write_data input.
REQ-012 write_strobe  out  1  pop-cycle indicator, aligned with the streamx write cadence.
REQ-013 level  out  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-014 running  out  1  high while the state is RUN.
REQ-015 underrun_cnt  out  16  count of strobes that found the FIFO empty (see Configuration).

Function
REQ-016 Push rule: a word is pushed when host_valid && host_ready; host_ready = !full && !flush, combinational from registered state.
REQ-017 FSM has two states. PRIME is the reset state; RUN is entered at the edge where PRIME holds and level >= PRIME_LVL.
REQ-018 Cadence counter is PERIOD_LOG2 bits and is cleared to 0 on entry to RUN.
REQ-019 In RUN the cadence counter increments every cycle, wrapping from all-ones to 0.
REQ-020 write_strobe = running && (cadence counter == all-ones); the first strobe occurs 2^PERIOD_LOG2 cycles after entry to RUN.
REQ-021 On a strobe with level > 0, the head word is popped and loaded into write_data at that edge; write_data holds until the next pop.
REQ-022 On a strobe with level == 0 (underrun), write_data holds its last value, no pop occurs, underrun_cnt increments, and the state stays RUN.
REQ-023 Push and pop in the same cycle leave level unchanged. No bypass: a push into an empty FIFO is not poppable until the next cycle.
REQ-024 Full: host_ready = 0, and a strobe in the same cycle still pops.
REQ-025 Empty in PRIME: no strobes are issued and write_data holds.
REQ-026 FIFO pointers are log2(DEPTH) bits, wrap naturally, and use one extra bit to distinguish full from empty.
REQ-027 Flush has priority over all events: pointers and level clear, the cadence counter clears, the state goes to PRIME, and write_data and underrun_cnt are retained.
REQ-028 A push or pop coincident with flush is discarded.
REQ-029 underrun_cnt saturates at 16'hFFFF.

Reset
REQ-030 While rst_l is low: state = PRIME, level = 0, pointers = 0, cadence counter = 0, write_data = 0, write_strobe = 0, running = 0, host_ready = 0, underrun_cnt = 0.
REQ-031 Reset asserted mid-operation SHALL abort immediately without completing a pending pop.
REQ-032 The first push is possible in the first cycle after rst_l deasserts.
REQ-033 FIFO storage is not reset; only the pointers and level are.

Configuration
REQ-034 Macro STREAMX_FEEDER_UNDERRUN_CNT_EN defined: underrun_cnt is implemented per REQ-022 and REQ-029.
REQ-035 Macro STREAMX_FEEDER_UNDERRUN_CNT_EN undefined: the counter logic is absent and underrun_cnt is tied to 16'h0; all other behaviour is identical.

Verification
REQ-036 Scenario prime: DEPTH=8, PRIME_LVL=2, PERIOD_LOG2=2; push 0xA1, then 0xA2 -> RUN one cycle after the second push; first strobe 4 cycles later; write_data=0xA1 the cycle after that strobe.
REQ-037 Scenario full: push 9 words back-to-back with no strobes (PRIME_LVL=8) -> host_ready=0 after the 8th word, level=8, and the 9th word is not accepted until a pop.
REQ-038 Scenario underrun: in RUN, stop pushing and let the FIFO drain -> at the next strobe, write_data holds the last word and underrun_cnt increments 0->1 (0 with the macro undefined).
REQ-039 Scenario flush: flush with level=5 in RUN, with host_valid asserted -> level=0, state PRIME, write_data unchanged, no word accepted in the flush cycle.
REQ-040 Scenario reset: assert rst_l low for 1 cycle in the middle of a strobe cycle -> all outputs take the REQ-030 values asynchronously, and after release the block behaves as in REQ-036.
REQ-041 Scenario wrap: stream 40 sequential words (0..39) with host_valid held high -> write_data follows 0..39 in order with no gaps or repeats across pointer wrap, and underrun_cnt stays 0.
